// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory loader: FSM state encoding and
// error codes reported on err_code.
package imem_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE = 2'd0;
    localparam logic [1:0] ERR_LEN  = 2'd1;
    localparam logic [1:0] ERR_CSUM = 2'd2;

    // The loader takes stream bytes only while parsing a load.
    function automatic logic state_accepts(input state_e s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) ||
               (s == ST_DATA)   || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_if.sv
// Byte-stream input and instruction-memory write port of the loader.
// A byte moves on a posedge where in_valid & in_ready; in_ready never looks at in_valid.
interface imem_loader_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_wr_en;
    logic [ADDR_W-1:0] mem_wr_addr;
    logic [7:0]        mem_wr_data;

    modport master (
        output in_valid, in_data,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data
    );
endinterface

// File: rtl/imem_loader.sv
// Loads a length-prefixed, XOR-checksummed program image into instruction
// memory from address 0, then releases the Y86-64 core via cpu_run.
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int MEM_BYTES = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load_start,
    imem_loader_if.slave        bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [1:0]          err_code,
    output logic                cpu_run,
    output state_e              dbg_state
);

    localparam int CW = ADDR_W + 1;
    localparam logic [16:0] MEM_BYTES_L = 17'(MEM_BYTES);

    state_e            state_q, state_d;
    logic [15:0]       len_q, len_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              error_q, error_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              cpu_run_q, cpu_run_d;

    logic              in_ready;
    logic              accept;
    logic [15:0]       n_full;
    logic [CW-1:0]     cnt_inc;

    assign in_ready = state_accepts(state_q);
    assign accept   = bus.in_valid & in_ready;
    assign n_full   = {bus.in_data, len_q[7:0]};
    assign cnt_inc  = cnt_q + CW'(1);

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        csum_d     = csum_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;
        done_d     = done_q;
        error_d    = error_q;
        err_code_d = err_code_q;
        cpu_run_d  = cpu_run_q;

        case (state_q)
            // A new load may begin from rest, after success, or after an abort.
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (load_start) begin
                    state_d    = ST_LEN_LO;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                    error_d    = 1'b0;
                    err_code_d = ERR_NONE;
                    cpu_run_d  = 1'b0;
                    len_d      = '0;
                    cnt_d      = '0;
                    csum_d     = '0;
                end
            end
            ST_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = bus.in_data;
                    state_d    = ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                if (accept) begin
                    len_d = n_full;
                    if ({1'b0, n_full} > MEM_BYTES_L) begin
                        state_d    = ST_ERR;
                        busy_d     = 1'b0;
                        error_d    = 1'b1;
                        err_code_d = ERR_LEN;
                    end else if (n_full == 16'd0) begin
                        state_d = ST_CSUM;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (accept) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = cnt_q[ADDR_W-1:0];
                    wr_data_d = bus.in_data;
                    cnt_d     = cnt_inc;
                    csum_d    = csum_q ^ bus.in_data;
                    if (32'(cnt_inc) == 32'(len_q)) begin
                        state_d = ST_CSUM;
                    end
                end
            end
            ST_CSUM: begin
                if (accept) begin
                    busy_d = 1'b0;
                    if (bus.in_data == csum_q) begin
                        state_d   = ST_DONE;
                        done_d    = 1'b1;
                        cpu_run_d = 1'b1;
                    end else begin
                        state_d    = ST_ERR;
                        error_d    = 1'b1;
                        err_code_d = ERR_CSUM;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            csum_q     <= '0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            err_code_q <= ERR_NONE;
            cpu_run_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            len_q      <= len_d;
            cnt_q      <= cnt_d;
            csum_q     <= csum_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            error_q    <= error_d;
            err_code_q <= err_code_d;
            cpu_run_q  <= cpu_run_d;
        end
    end

    assign bus.in_ready    = in_ready;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_wr_addr = wr_addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign error           = error_q;
    assign err_code        = err_code_q;
    assign cpu_run         = cpu_run_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: directed and random load streams scored against a
// stream-level model of the expected memory writes and final status.
module tb_imem_loader;
    import imem_loader_pkg::*;

    localparam int MEM_BYTES = 1024;
    localparam int ADDR_W    = 10;
    localparam int EXP_W     = 32 + ADDR_W + 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        load_start = 1'b0;
    logic        busy, done, error, cpu_run;
    logic [1:0]  err_code;
    state_e      dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    int unsigned cyc      = 0;

    logic [EXP_W-1:0] exp_q[$];
    logic [7:0]       stim_q[$];
    logic [EXP_W-1:0] mon_e;

    imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

    imem_loader #(.MEM_BYTES(MEM_BYTES), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .load_start (load_start),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .err_code   (err_code),
        .cpu_run    (cpu_run),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Every write must match the oldest expected write, one cycle after its accept.
    always @(negedge clk) begin
        if (bus.mem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("wr_unexpected", 32'(bus.mem_wr_addr), 32'hFFFF_FFFF);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr",  32'(bus.mem_wr_addr), 32'(mon_e[ADDR_W+7 -: ADDR_W]));
                check("wr_data",  32'(bus.mem_wr_data), 32'(mon_e[7:0]));
                check("wr_cycle", cyc, mon_e[EXP_W-1 -: 32]);
            end
        end
    end

    task automatic check_reset_outputs();
        check("rst_busy",     32'(busy),            32'd0);
        check("rst_done",     32'(done),            32'd0);
        check("rst_error",    32'(error),           32'd0);
        check("rst_err_code", 32'(err_code),        32'd0);
        check("rst_cpu_run",  32'(cpu_run),         32'd0);
        check("rst_in_ready", 32'(bus.in_ready),    32'd0);
        check("rst_wr_en",    32'(bus.mem_wr_en),   32'd0);
        check("rst_wr_addr",  32'(bus.mem_wr_addr), 32'd0);
        check("rst_wr_data",  32'(bus.mem_wr_data), 32'd0);
    endtask

    task automatic check_status(input bit exp_done, input bit exp_err, input int exp_code);
        check("done",       32'(done),       32'(exp_done));
        check("error",      32'(error),      32'(exp_err));
        check("err_code",   32'(err_code),   32'(exp_code));
        check("cpu_run",    32'(cpu_run),    32'(exp_done));
        check("busy_end",   32'(busy),       32'd0);
        check("ready_end",  32'(bus.in_ready), 32'd0);
        check("wr_pending", 32'(exp_q.size()), 32'd0);
    endtask

    // ---------------- driver ----------------
    // Entered and left just after a negedge. Queues the expected write when
    // the model classes this byte as program data.
    task automatic drive_byte(input logic [7:0] b, input int gaps, input bit is_data,
                              input int addr, input bit busy_pulse);
        int waited;
        bus.in_valid = 1'b0;
        repeat (gaps) @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        load_start   = busy_pulse;
        waited = 0;
        while (bus.in_ready !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) begin
            $display("FAIL ready_timeout: in_ready stuck low, state %0d", dbg_state);
            n_checks++;
            n_fail++;
            bus.in_valid = 1'b0;
            load_start   = 1'b0;
            return;
        end
        if (is_data) exp_q.push_back({32'(cyc + 1), ADDR_W'(addr), b});
        @(negedge clk);
        bus.in_valid = 1'b0;
        load_start   = 1'b0;
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        @(negedge clk);
        load_start = 1'b0;
    endtask

    // Model: derive N, data positions and outcome from stim_q, then drive it.
    // gap_mode 0 = back-to-back, 1 = valid toggles, 2 = random gaps + busy load_start.
    task automatic run_load(input int gap_mode);
        int  n;
        bit  ovf;
        bit  exp_ok;
        logic [7:0] x;
        int  gaps;
        bit  is_data;
        bit  bp;
        n   = int'({stim_q[1], stim_q[0]});
        ovf = (n > MEM_BYTES);
        x   = 8'h00;
        exp_ok = 1'b0;
        if (!ovf) begin
            for (int i = 0; i < n; i++) x ^= stim_q[2 + i];
            exp_ok = (stim_q[n + 2] == x);
        end
        pulse_start();
        check("busy_start",  32'(busy),         32'd1);
        check("ready_start", 32'(bus.in_ready), 32'd1);
        for (int i = 0; i < stim_q.size(); i++) begin
            gaps = 0;
            bp   = 1'b0;
            if (gap_mode == 1 && i > 0) gaps = 1;
            if (gap_mode == 2) begin
                gaps = int'($urandom_range(0, 3));
                bp   = (i >= 1) && ($urandom_range(0, 5) == 0);
            end
            is_data = !ovf && (i >= 2) && (i < n + 2);
            drive_byte(stim_q[i], gaps, is_data, i - 2, bp);
        end
        if (ovf)         check_status(1'b0, 1'b1, 1);
        else if (exp_ok) check_status(1'b1, 1'b0, 0);
        else             check_status(1'b0, 1'b1, 2);
    endtask

    task automatic set_test1();
        stim_q = '{8'h03, 8'h00, 8'h30, 8'hF2, 8'h00, 8'hC2};
    endtask

    task automatic build_random(input int kind);
        int n;
        logic [7:0] x;
        logic [7:0] b;
        stim_q.delete();
        if (kind == 0) n = int'($urandom_range(MEM_BYTES + 1, 65535));
        else if (kind == 1) n = MEM_BYTES;
        else n = int'($urandom_range(0, 24));
        stim_q.push_back(n[7:0]);
        stim_q.push_back(n[15:8]);
        if (n > MEM_BYTES) return;
        x = 8'h00;
        for (int i = 0; i < n; i++) begin
            b = 8'($urandom_range(0, 255));
            stim_q.push_back(b);
            x ^= b;
        end
        if ($urandom_range(0, 3) == 0) x ^= 8'($urandom_range(1, 255));
        stim_q.push_back(x);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (3) @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);

        // basic three-byte image
        set_test1();
        run_load(0);
        // empty image
        stim_q = '{8'h00, 8'h00, 8'h00};
        run_load(0);
        // length one past memory size
        stim_q = '{8'h01, 8'h04};
        run_load(0);
        // bad checksum after one written byte
        stim_q = '{8'h01, 8'h00, 8'h10, 8'h11};
        run_load(0);
        // valid toggling every cycle
        set_test1();
        run_load(1);

        // reset in the middle of the data phase
        pulse_start();
        drive_byte(8'h03, 0, 1'b0, 0, 1'b0);
        drive_byte(8'h00, 0, 1'b0, 0, 1'b0);
        drive_byte(8'h30, 0, 1'b1, 0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs();
        check("rst_wr_pending", 32'(exp_q.size()), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        set_test1();
        run_load(0);
        // restart straight out of DONE
        pulse_start();
        check("restart_done",    32'(done),    32'd0);
        check("restart_cpu_run", 32'(cpu_run), 32'd0);
        check("restart_busy",    32'(busy),    32'd1);

        // completely full memory
        build_random(1);
        run_load(0);

        for (int t = 0; t < 14; t++) begin
            build_random((t % 7 == 3) ? 0 : 2);
            run_load(int'($urandom_range(0, 2)));
        end

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Hard stop if something wedges outside the bounded waits.
    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not complete");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory that the sequential Y86-64 core reads through its fetch stage.
- Accepts a byte stream over a valid/ready handshake and writes the program image into instruction memory starting at address 0.
- Verifies a length header and an XOR checksum, then asserts cpu_run to release the core from PC=0.
- Sits between the bench/host byte source and the instruction memory write port.

Parameters:
MEM_BYTES, 1024, instruction memory size in bytes
ADDR_W, 10, instruction memory address width; MEM_BYTES <= 2^ADDR_W

Ports:
clk  input  1  system clock; all state updates on posedge
rst  input  1  synchronous, active-high reset
load_start  input  1  one-cycle pulse that begins a load
in_valid  input  1  byte source has in_data available
in_data  input  8  stream byte
in_ready  output  1  loader accepts in_data this cycle
mem_wr_en  output  1  instruction memory write strobe
mem_wr_addr  output  ADDR_W  write byte address
mem_wr_data  output  8  write byte
busy  output  1  load in progress
done  output  1  image loaded and checksum good
error  output  1  load aborted
err_code  output  2  0=none, 1=length overflow, 2=checksum mismatch
cpu_run  output  1  core may fetch; low holds core at PC 0

Behaviour:
- Reset: state IDLE; all outputs 0; byte counter, length and checksum registers 0. Instruction memory contents are not touched. Reset applies from any state, including mid-DATA.
- Handshake: a byte is accepted when in_valid & in_ready on a posedge. in_ready is combinational from state: 1 in LEN_LO, LEN_HI, DATA and CSUM; 0 in IDLE, DONE and ERR. in_ready never depends on in_valid.
- Stream format: LEN_LO, LEN_HI (16-bit little-endian byte count N), then N program bytes, then 1 checksum byte equal to the XOR of the N program bytes.
- States:
  - IDLE: on load_start go to LEN_LO; set busy=1, clear done, error, err_code, cpu_run, counter and checksum.
  - LEN_LO: on accept, latch low byte, go to LEN_HI.
  - LEN_HI: on accept, latch high byte. If N > MEM_BYTES, go to ERR with err_code=1. Else if N == 0, go to CSUM. Else go to DATA.
  - DATA: on accept, register a write: the next cycle has mem_wr_en=1, mem_wr_addr=counter, mem_wr_data=byte (one-cycle latency, one write per accepted byte). Counter increments and checksum ^= byte. On the Nth byte, go to CSUM.
  - CSUM: on accept, compare the byte to the checksum. Match: go to DONE. Mismatch: go to ERR with err_code=2.
  - DONE: busy=0, done=1, cpu_run=1, held. load_start clears done and cpu_run on the next edge and re-enters LEN_LO.
  - ERR: busy=0, error=1, cpu_run=0, err_code held. load_start restarts as from IDLE.
- load_start while busy=1 is ignored.
- Cycles with in_valid=0 stall with no state change. Gaps between bytes are allowed anywhere in the stream.
- mem_wr_en is low in every cycle not immediately following a DATA accept. Bytes already written before an error remain in memory.
- The counter is ADDR_W+1 bits wide, so N == MEM_BYTES fills addresses 0..MEM_BYTES-1 with no wrap.
- Status outputs are registered. done and error are never high together.

Decomposition:
- Shared package: state encoding (IDLE, LEN_LO, LEN_HI, DATA, CSUM, DONE, ERR), err_code constants (ERR_NONE=0, ERR_LEN=1, ERR_CSUM=2).
- No sub-module: a single FSM with a counter and an XOR accumulator.

Test Plan:
1. load_start; stream 03,00,30,F2,00,C2 with in_valid=1 continuous -> writes (0,30),(1,F2),(2,00), each one cycle after its accept; then done=1, cpu_run=1, error=0, err_code=0.
2. Stream 00,00,00 -> zero writes; done=1 after the checksum byte.
3. Stream 01,04 (N=1025, MEM_BYTES=1024) -> error=1, err_code=1, in_ready=0, no writes, cpu_run=0.
4. Stream 01,00,10,11 -> write (0,10); then error=1, err_code=2, done=0, cpu_run=0.
5. Test 1 stream with in_valid toggling 1/0 every cycle -> same writes and result, no duplicate writes.
6. Assert rst after the first DATA byte -> next cycle all outputs 0, in_ready=0; then reload test 1 -> done=1. Next, pulse load_start in DONE -> done and cpu_run=0 the next cycle, busy=1.
